// File: rtl/motor_pkg.sv
// Shared constants for the motor overcurrent guard.
// FSM state encodings double as the per-channel status code.
`timescale 1ns/1ps
package motor_pkg;

   localparam logic [1:0] ST_RUN  = 2'b00;
   localparam logic [1:0] ST_COOL = 2'b01;
   localparam logic [1:0] ST_LOCK = 2'b10;

   localparam logic [1:0] STATUS_RUN  = ST_RUN;
   localparam logic [1:0] STATUS_COOL = ST_COOL;
   localparam logic [1:0] STATUS_LOCK = ST_LOCK;

   localparam int RETRY_W = 3;

endpackage

// File: rtl/motor_fault_guard_oc_channel_guard.sv
// One channel of the overcurrent guard: OC sync, filter, timer, FSM, output regs.
// Ports: clk, rst_n, oc, en_req, in_req[1:0], clr_fault -> en_out, in_out[1:0], status[1:0], retries[2:0].
`timescale 1ns/1ps
module oc_channel_guard
   import motor_pkg::*;
#(
   parameter int FILT_CYCLES     = 1000,
   parameter int COOLDOWN_CYCLES = 50_000_000,
   parameter int MAX_RETRY       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       oc,
   input  logic       en_req,
   input  logic [1:0] in_req,
   input  logic       clr_fault,
   output logic       en_out,
   output logic [1:0] in_out,
   output logic [1:0] status,
   output logic [2:0] retries
);

   localparam int FW = $clog2(FILT_CYCLES + 1);
   localparam int TW = $clog2(COOLDOWN_CYCLES + 1);

   localparam logic [FW-1:0] FILT_MAX  = FW'(FILT_CYCLES);
   localparam logic [FW-1:0] FILT_PRE  = FW'(FILT_CYCLES - 1);
   localparam logic [TW-1:0] COOL_END  = TW'(COOLDOWN_CYCLES);
   localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN_CYCLES - 1);
   localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic [FW-1:0] filt_q, filt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    retries_q, retries_d;
   logic          en_q, en_d;
   logic [1:0]    in_q, in_d;

   logic          trip;
   logic [3:0]    retry_inc;

   // trip fires only on the edge the count reaches the limit,
   // so a held fault trips once until it drops.
   assign trip      = s2_q && (filt_q == FILT_PRE);
   assign retry_inc = {1'b0, retries_q} + 4'd1;

   always_comb begin
      s1_d      = oc;
      s2_d      = s1_q;
      filt_d    = '0;
      state_d   = state_q;
      timer_d   = timer_q;
      retries_d = retries_q;
      en_d      = 1'b0;
      in_d      = 2'b00;

      if (s2_q) begin
         filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + FW'(1);
      end

      case (state_q)
         ST_RUN: begin
            if (trip) begin
               timer_d = '0;
               if (retry_inc > RETRY_LIM) begin
                  state_d   = ST_LOCK;
                  retries_d = RETRY_LIM[2:0];
               end else begin
                  state_d   = ST_COOL;
                  retries_d = retry_inc[2:0];
               end
            end else begin
               en_d = en_req;
               in_d = in_req;
               if (timer_q == COOL_END) begin
                  retries_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         end
         ST_COOL: begin
            if (timer_q == COOL_LAST) begin
               state_d = ST_RUN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_LOCK: begin
            if (clr_fault && !s2_q) begin
               state_d   = ST_RUN;
               retries_d = '0;
               timer_d   = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         filt_q    <= '0;
         timer_q   <= '0;
         state_q   <= ST_RUN;
         retries_q <= '0;
         en_q      <= 1'b0;
         in_q      <= 2'b00;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         filt_q    <= filt_d;
         timer_q   <= timer_d;
         state_q   <= state_d;
         retries_q <= retries_d;
         en_q      <= en_d;
         in_q      <= in_d;
      end
   end

   assign en_out  = en_q;
   assign in_out  = in_q;
   assign status  = state_q;
   assign retries = retries_q;

endmodule

// File: rtl/motor_fault_guard.sv
// Two-channel H-bridge overcurrent guard; A = bit/field 0, B = bit/field 1.
// Ports: clk, rst_n, oc[1:0], en_req[1:0], in_req[3:0], clr_fault -> en_out, in_out, status, retries.
`timescale 1ns/1ps
module motor_fault_guard
   import motor_pkg::*;
#(
   parameter int FILT_CYCLES     = 1000,
   parameter int COOLDOWN_CYCLES = 50_000_000,
   parameter int MAX_RETRY       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] oc,
   input  logic [1:0] en_req,
   input  logic [3:0] in_req,
   input  logic       clr_fault,
   output logic [1:0] en_out,
   output logic [3:0] in_out,
   output logic [3:0] status,
   output logic [5:0] retries
);

   for (genvar c = 0; c < 2; c++) begin : g_ch
      oc_channel_guard #(
         .FILT_CYCLES     (FILT_CYCLES),
         .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
         .MAX_RETRY       (MAX_RETRY)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .oc        (oc[c]),
         .en_req    (en_req[c]),
         .in_req    (in_req[2*c +: 2]),
         .clr_fault (clr_fault),
         .en_out    (en_out[c]),
         .in_out    (in_out[2*c +: 2]),
         .status    (status[2*c +: 2]),
         .retries   (retries[3*c +: 3])
      );
   end

endmodule

// File: tb/tb_motor_fault_guard.sv
// Directed bench for motor_fault_guard.
// FILT=4, COOLDOWN=16, MAX_RETRY=2.
`timescale 1ns/1ps
module tb_motor_fault_guard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] oc;
   logic [1:0] en_req;
   logic [3:0] in_req;
   logic       clr_fault;
   logic [1:0] en_out;
   logic [3:0] in_out;
   logic [3:0] status;
   logic [5:0] retries;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   motor_fault_guard #(
      .FILT_CYCLES     (4),
      .COOLDOWN_CYCLES (16),
      .MAX_RETRY       (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .oc        (oc),
      .en_req    (en_req),
      .in_req    (in_req),
      .clr_fault (clr_fault),
      .en_out    (en_out),
      .in_out    (in_out),
      .status    (status),
      .retries   (retries)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // trip a channel: 2 sync + 4 filter edges, then release oc
   task automatic trip_ch(input int ch);
      oc[ch] = 1'b1;
      tick(6);
      oc[ch] = 1'b0;
   endtask

   task automatic wait_run(input int ch, input string tag);
      for (int i = 0; i < 40; i++) begin
         if (status[2*ch +: 2] == 2'b00) break;
         tick(1);
      end
      chk(tag, int'(status[2*ch +: 2]), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      oc        = 2'b00;
      en_req    = 2'b00;
      in_req    = 4'b0000;
      clr_fault = 1'b0;
      tick(3);
      chk("rst_en", en_out, 0);
      chk("rst_in", in_out, 0);
      chk("rst_st", status, 0);
      chk("rst_rt", retries, 0);

      rst_n = 1'b1;
      tick(1);
      en_req = 2'b11;
      in_req = 4'b1001;
      tick(1);
      chk("t1_en", en_out, 2'b11);
      chk("t1_in", in_out, 4'b1001);
      chk("t1_st", status, 0);

      // short glitch on A: filter never reaches 4
      oc[0] = 1'b1;
      tick(3);
      oc[0] = 1'b0;
      tick(8);
      chk("t2_glitch_en", en_out, 2'b11);
      chk("t2_glitch_st", status, 0);

      // real trip on A: en drops on the 6th edge after the rise
      oc[0] = 1'b1;
      tick(5);
      chk("t2_pre_en", en_out, 2'b11);
      tick(1);
      oc[0] = 1'b0;
      chk("t2_trip_en", en_out, 2'b10);
      chk("t2_trip_in", in_out, 4'b1000);
      chk("t2_trip_st", status, 4'b0001);
      chk("t2_trip_rt", retries, 6'o01);

      // cooldown: RUN after 16 edges, outputs one edge later
      tick(15);
      chk("t3_cool15_st", status, 4'b0001);
      chk("t3_cool15_en", en_out, 2'b10);
      tick(1);
      chk("t3_cool16_st", status, 0);
      chk("t3_cool16_en", en_out, 2'b10);
      tick(1);
      chk("t3_back_en", en_out, 2'b11);
      chk("t3_back_in", in_out, 4'b1001);
      chk("t3_back_rt", retries, 6'o01);
      tick(20);
      chk("t3_clean_rt", retries, 6'o00);

      // three trips on B -> lockout
      trip_ch(1);
      chk("t4_b1_st", status, 4'b0100);
      chk("t4_b1_rt", retries, 6'o10);
      chk("t4_b1_a", en_out, 2'b01);
      wait_run(1, "t4_b1_run");
      trip_ch(1);
      chk("t4_b2_st", status, 4'b0100);
      chk("t4_b2_rt", retries, 6'o20);
      wait_run(1, "t4_b2_run");
      oc[1] = 1'b1;
      tick(6);
      chk("t4_b3_st", status, 4'b1000);
      chk("t4_b3_rt", retries, 6'o20);
      chk("t4_b3_en", en_out, 2'b01);
      chk("t4_b3_in", in_out, 4'b0001);

      clr_fault = 1'b1;
      tick(2);
      clr_fault = 1'b0;
      tick(1);
      chk("t4_clr_oc_st", status, 4'b1000);
      chk("t4_clr_oc_rt", retries, 6'o20);

      oc[1] = 1'b0;
      tick(3);
      chk("t4_hold_st", status, 4'b1000);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("t4_clr_st", status, 0);
      chk("t4_clr_rt", retries, 0);
      tick(1);
      chk("t4_clr_en", en_out, 2'b11);

      // clr_fault during cooldown is ignored
      trip_ch(0);
      chk("t5_trip_st", status, 4'b0001);
      tick(5);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      tick(9);
      chk("t5_cool15_st", status, 4'b0001);
      chk("t5_cool15_en", en_out, 2'b10);
      tick(1);
      chk("t5_cool16_st", status, 0);
      tick(1);
      chk("t5_back_en", en_out, 2'b11);

      // reset out of lockout
      tick(20);
      trip_ch(1);
      wait_run(1, "t6_b1_run");
      trip_ch(1);
      wait_run(1, "t6_b2_run");
      trip_ch(1);
      chk("t6_lock_st", status, 4'b1000);
      rst_n = 1'b0;
      tick(1);
      chk("t6_rst_st", status, 0);
      chk("t6_rst_rt", retries, 0);
      chk("t6_rst_en", en_out, 0);
      chk("t6_rst_in", in_out, 0);
      rst_n = 1'b1;
      tick(1);
      chk("t6_post_en", en_out, 2'b11);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
